// File: rtl/score_keeper_pkg.sv
// Shared constants and state encoding for the match controller and its consumers.
package score_keeper_pkg;

  localparam logic [2:0] NO_WINNER      = 3'b000;
  localparam logic [2:0] PLAYER_1_COLOR = 3'b100;
  localparam logic [2:0] PLAYER_2_COLOR = 3'b001;

  localparam int DEFAULT_WIN_SCORE = 7;

  typedef enum logic [1:0] {
    SK_PAUSE = 2'd0,
    SK_PLAY  = 2'd1,
    SK_WIN   = 2'd2
  } sk_state_e;

endpackage

// File: rtl/score_keeper_if.sv
// Event inputs from ball/button logic and match outputs toward the renderers.
interface score_keeper_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               goal_p1;
  logic               goal_p2;
  logic               restart;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [2:0]         winner;
  logic               game_active;
  logic               serve_dir;

  modport master (
    output frame_tick, goal_p1, goal_p2, restart,
    input  score_p1, score_p2, winner, game_active, serve_dir
  );

  modport slave (
    input  frame_tick, goal_p1, goal_p2, restart,
    output score_p1, score_p2, winner, game_active, serve_dir
  );
endinterface

// File: rtl/score_keeper_rise_edge.sv
// Rising-edge detector for a debounced level; reset value of the history bit is
// configurable so a level held through reset can be kept from firing.
module rise_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);
  logic r_level_q;

  always_ff @(posedge clk) begin
    if (rst) r_level_q <= RST_VAL;
    else     r_level_q <= i_level;
  end

  assign o_pulse = i_level & ~r_level_q;
endmodule

// File: rtl/score_keeper.sv
// Match controller: counts goals, paces serves in frame ticks, latches the winner
// until a restart press.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  sk
);
  localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_FRAMES);

  sk_state_e          r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_score_p1, r_score_p2, w_score_p1_nxt, w_score_p2_nxt;
  logic [SCORE_W-1:0] w_p1_inc, w_p2_inc;
  logic [2:0]         r_winner, w_winner_nxt;
  logic               r_serve_dir, w_serve_dir_nxt;
  logic [CNT_W-1:0]   r_pause_cnt, w_pause_cnt_nxt;
  logic               r_game_active;
  logic               w_restart_pulse;

  // Held-through-reset restart must not count as a press.
  rise_edge #(.RST_VAL(1'b1)) u_restart_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (sk.restart),
    .o_pulse (w_restart_pulse)
  );

  assign w_p1_inc = r_score_p1 + SCORE_W'(1);
  assign w_p2_inc = r_score_p2 + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SK_PAUSE;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_winner      <= NO_WINNER;
      r_serve_dir   <= 1'b0;
      r_pause_cnt   <= PAUSE_LOAD;
      r_game_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_score_p1    <= w_score_p1_nxt;
      r_score_p2    <= w_score_p2_nxt;
      r_winner      <= w_winner_nxt;
      r_serve_dir   <= w_serve_dir_nxt;
      r_pause_cnt   <= w_pause_cnt_nxt;
      r_game_active <= (w_state_nxt == SK_PLAY);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_score_p1_nxt  = r_score_p1;
    w_score_p2_nxt  = r_score_p2;
    w_winner_nxt    = r_winner;
    w_serve_dir_nxt = r_serve_dir;
    w_pause_cnt_nxt = r_pause_cnt;

    if (w_restart_pulse) begin
      w_state_nxt     = SK_PAUSE;
      w_score_p1_nxt  = '0;
      w_score_p2_nxt  = '0;
      w_winner_nxt    = NO_WINNER;
      w_pause_cnt_nxt = PAUSE_LOAD;
      // Serve toward the loser of the finished match: P1 won -> toward P2.
      if (r_state == SK_WIN) w_serve_dir_nxt = (r_winner == PLAYER_1_COLOR);
    end else begin
      unique case (r_state)
        SK_PAUSE: begin
          if (sk.frame_tick) begin
            if (r_pause_cnt == CNT_W'(1)) w_state_nxt = SK_PLAY;
            else                          w_pause_cnt_nxt = r_pause_cnt - CNT_W'(1);
          end
        end
        SK_PLAY: begin
          if (sk.goal_p1 && !sk.goal_p2) begin
            w_score_p1_nxt = w_p1_inc;
            if (w_p1_inc == WIN_VAL) begin
              w_state_nxt  = SK_WIN;
              w_winner_nxt = PLAYER_1_COLOR;
            end else begin
              w_state_nxt     = SK_PAUSE;
              w_pause_cnt_nxt = PAUSE_LOAD;
              w_serve_dir_nxt = 1'b1;
            end
          end else if (sk.goal_p2 && !sk.goal_p1) begin
            w_score_p2_nxt = w_p2_inc;
            if (w_p2_inc == WIN_VAL) begin
              w_state_nxt  = SK_WIN;
              w_winner_nxt = PLAYER_2_COLOR;
            end else begin
              w_state_nxt     = SK_PAUSE;
              w_pause_cnt_nxt = PAUSE_LOAD;
              w_serve_dir_nxt = 1'b0;
            end
          end
        end
        SK_WIN: ;
        default: w_state_nxt = SK_PAUSE;
      endcase
    end
  end

  assign sk.score_p1    = r_score_p1;
  assign sk.score_p2    = r_score_p2;
  assign sk.winner      = r_winner;
  assign sk.game_active = r_game_active;
  assign sk.serve_dir   = r_serve_dir;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with default parameters (win at 7, 60-frame pause).
module tb_score_keeper;
  import score_keeper_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  score_keeper_if #(.SCORE_W(4)) sk ();

  score_keeper #(.WIN_SCORE(7), .PAUSE_FRAMES(60), .SCORE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .sk  (sk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic ft, input logic g1, input logic g2);
    sk.frame_tick = ft;
    sk.goal_p1    = g1;
    sk.goal_p2    = g2;
    @(posedge clk);
    #1;
    sk.frame_tick = 1'b0;
    sk.goal_p1    = 1'b0;
    sk.goal_p2    = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sk.restart = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    n_checks++; if (sk.score_p1 !== 4'd0) begin n_fail++; $display("FAIL reset_score_p1 got %0d exp 0", sk.score_p1); end
    n_checks++; if (sk.score_p2 !== 4'd0) begin n_fail++; $display("FAIL reset_score_p2 got %0d exp 0", sk.score_p2); end
    n_checks++; if (sk.winner !== NO_WINNER) begin n_fail++; $display("FAIL reset_winner got %b exp %b", sk.winner, NO_WINNER); end
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL reset_game_active got %b exp 0", sk.game_active); end
    n_checks++; if (sk.serve_dir !== 1'b0) begin n_fail++; $display("FAIL reset_serve_dir got %b exp 0", sk.serve_dir); end
  endtask

  task automatic test_serve_pacing;
    run_ticks(30);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    run_ticks(29);
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL pace_59_ticks game_active got %b exp 0", sk.game_active); end
    run_ticks(1);
    n_checks++; if (sk.game_active !== 1'b1) begin n_fail++; $display("FAIL pace_60_ticks game_active got %b exp 1", sk.game_active); end
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h00) begin n_fail++; $display("FAIL pace_scores got %0d:%0d exp 0:0", sk.score_p1, sk.score_p2); end
  endtask

  task automatic test_goal_p1;
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (sk.score_p1 !== 4'd1) begin n_fail++; $display("FAIL goal_p1_score got %0d exp 1", sk.score_p1); end
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL goal_p1_game_active got %b exp 0", sk.game_active); end
    n_checks++; if (sk.serve_dir !== 1'b1) begin n_fail++; $display("FAIL goal_p1_serve_dir got %b exp 1", sk.serve_dir); end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h10) begin n_fail++; $display("FAIL pause_goal_ignored got %0d:%0d exp 1:0", sk.score_p1, sk.score_p2); end
    run_ticks(59);
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL reload_59 game_active got %b exp 0", sk.game_active); end
    run_ticks(1);
    n_checks++; if (sk.game_active !== 1'b1) begin n_fail++; $display("FAIL reload_60 game_active got %b exp 1", sk.game_active); end
  endtask

  task automatic test_both_goals;
    step(1'b0, 1'b1, 1'b1);
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h10) begin n_fail++; $display("FAIL both_goals_scores got %0d:%0d exp 1:0", sk.score_p1, sk.score_p2); end
    n_checks++; if (sk.game_active !== 1'b1) begin n_fail++; $display("FAIL both_goals_game_active got %b exp 1", sk.game_active); end
  endtask

  task automatic test_p2_win;
    logic [10:0] frozen;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++; if (sk.score_p2 !== 4'(k)) begin n_fail++; $display("FAIL p2_climb score_p2 got %0d exp %0d", sk.score_p2, k); end
      n_checks++; if (sk.serve_dir !== 1'b0) begin n_fail++; $display("FAIL p2_climb serve_dir got %b exp 0", sk.serve_dir); end
      run_ticks(60);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (sk.score_p2 !== 4'd7) begin n_fail++; $display("FAIL p2_win score_p2 got %0d exp 7", sk.score_p2); end
    n_checks++; if (sk.winner !== PLAYER_2_COLOR) begin n_fail++; $display("FAIL p2_win winner got %b exp %b", sk.winner, PLAYER_2_COLOR); end
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL p2_win game_active got %b exp 0", sk.game_active); end
    frozen = {4'd1, 4'd7, PLAYER_2_COLOR};
    for (int i = 0; i < 1000; i++) begin
      step(i[0], (i % 3) == 0, (i % 5) == 0);
      n_checks++;
      if ({sk.score_p1, sk.score_p2, sk.winner} !== frozen || sk.game_active !== 1'b0) begin
        n_fail++;
        $display("FAIL win_frozen cycle %0d got %0d:%0d w=%b ga=%b exp 1:7 w=%b ga=0",
                 i, sk.score_p1, sk.score_p2, sk.winner, sk.game_active, PLAYER_2_COLOR);
      end
    end
  endtask

  task automatic test_restart_from_win;
    sk.restart = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h00) begin n_fail++; $display("FAIL restart_scores got %0d:%0d exp 0:0", sk.score_p1, sk.score_p2); end
    n_checks++; if (sk.winner !== NO_WINNER) begin n_fail++; $display("FAIL restart_winner got %b exp %b", sk.winner, NO_WINNER); end
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL restart_game_active got %b exp 0", sk.game_active); end
    n_checks++; if (sk.serve_dir !== 1'b0) begin n_fail++; $display("FAIL restart_serve_toward_p1 got %b exp 0", sk.serve_dir); end
    run_ticks(59);
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL held_restart_59 game_active got %b exp 0", sk.game_active); end
    run_ticks(1);
    n_checks++; if (sk.game_active !== 1'b1) begin n_fail++; $display("FAIL held_restart_no_retrigger game_active got %b exp 1", sk.game_active); end
    sk.restart = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_p1_win_restart;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (sk.score_p1 !== 4'(k)) begin n_fail++; $display("FAIL p1_climb score_p1 got %0d exp %0d", sk.score_p1, k); end
      run_ticks(60);
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (sk.winner !== PLAYER_1_COLOR) begin n_fail++; $display("FAIL p1_win winner got %b exp %b", sk.winner, PLAYER_1_COLOR); end
    n_checks++; if (sk.score_p1 !== 4'd7) begin n_fail++; $display("FAIL p1_win score_p1 got %0d exp 7", sk.score_p1); end
    sk.restart = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h00) begin n_fail++; $display("FAIL restart_prio_scores got %0d:%0d exp 0:0", sk.score_p1, sk.score_p2); end
    n_checks++; if (sk.winner !== NO_WINNER) begin n_fail++; $display("FAIL restart_prio_winner got %b exp %b", sk.winner, NO_WINNER); end
    n_checks++; if (sk.serve_dir !== 1'b1) begin n_fail++; $display("FAIL restart_serve_toward_p2 got %b exp 1", sk.serve_dir); end
    sk.restart = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_held_through_rst;
    sk.restart = 1'b1;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run_ticks(59);
    n_checks++; if (sk.game_active !== 1'b0) begin n_fail++; $display("FAIL rst_held_59 game_active got %b exp 0", sk.game_active); end
    run_ticks(1);
    n_checks++; if (sk.game_active !== 1'b1) begin n_fail++; $display("FAIL rst_held_no_pulse game_active got %b exp 1", sk.game_active); end
    sk.restart = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid_play;
    logic [4:0] seq;
    seq = 5'b11100;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, seq[k], ~seq[k]);
      run_ticks(60);
    end
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h32) begin n_fail++; $display("FAIL pre_rst_scores got %0d:%0d exp 3:2", sk.score_p1, sk.score_p2); end
    n_checks++; if ({sk.game_active, sk.serve_dir} !== 2'b11) begin n_fail++; $display("FAIL pre_rst ga/serve got %b%b exp 11", sk.game_active, sk.serve_dir); end
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    n_checks++; if ({sk.score_p1, sk.score_p2} !== 8'h00) begin n_fail++; $display("FAIL mid_rst_scores got %0d:%0d exp 0:0", sk.score_p1, sk.score_p2); end
    n_checks++; if (sk.winner !== NO_WINNER) begin n_fail++; $display("FAIL mid_rst_winner got %b exp %b", sk.winner, NO_WINNER); end
    n_checks++; if ({sk.game_active, sk.serve_dir} !== 2'b00) begin n_fail++; $display("FAIL mid_rst ga/serve got %b%b exp 00", sk.game_active, sk.serve_dir); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    sk.frame_tick = 1'b0;
    sk.goal_p1    = 1'b0;
    sk.goal_p2    = 1'b0;
    sk.restart    = 1'b0;
    test_reset();
    test_serve_pacing();
    test_goal_p1();
    test_both_goals();
    test_p2_win();
    test_restart_from_win();
    test_p1_win_restart();
    test_restart_held_through_rst();
    test_rst_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
